// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 1-cycle RAM, plus an I/O window at
// mem_a[17:16]==2'b11 with UART RX/TX FIFOs, a snapshot-able cycle counter and a halt flag.
module mem_io_responder #(
   parameter int RAM_ADDR_W = 17,
   parameter int FIFO_AW    = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0] TX_ALMOST = (FIFO_AW + 1)'(DEPTH - 1);

   logic [1:0]            region;
   logic [2:0]            io_off;
   logic [RAM_ADDR_W-1:0] ram_addr;
   logic                  is_ram;
   logic                  is_io;
   logic                  bus_rd;
   logic                  bus_wr;
   logic                  unused_addr_bits;

   assign region           = mem_a[17:16];
   assign io_off           = mem_a[2:0];
   assign ram_addr         = mem_a[RAM_ADDR_W-1:0];
   assign is_ram           = ~region[1];
   assign is_io            = &region;
   assign bus_rd           = rdy_in & ~mem_wr;
   assign bus_wr           = rdy_in & mem_wr;
   assign unused_addr_bits = ^mem_a[31:18];

   // RAM contents survive reset, so no reset branch here.
   logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];

   always_ff @(posedge clk_in) begin
      if (!rst_in && bus_wr && is_ram)
         ram[ram_addr] <= mem_dout;
   end

   // RX FIFO: UART side pushes, bus reads of offset 0 pop.
   logic [7:0]       rx_mem [0:DEPTH-1];
   logic [FIFO_AW:0] rx_wp;
   logic [FIFO_AW:0] rx_rp;
   logic             rx_empty;
   logic             rx_full;
   logic             rx_push;
   logic             rx_pop;
   logic [7:0]       rx_head;

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                     (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
   assign rx_ready = ~rx_full;
   assign rx_push  = rx_valid & ~rx_full;
   assign rx_pop   = bus_rd & is_io & (io_off == 3'd0) & ~rx_empty;
   assign rx_head  = rx_mem[rx_rp[FIFO_AW-1:0]];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push)
            rx_wp <= rx_wp + PTR_ONE;
         if (rx_pop)
            rx_rp <= rx_rp + PTR_ONE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rx_push)
         rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_data;
   end

   // TX FIFO: bus writes push (offset 4 pushes a 0x00 terminator), UART side pops.
   logic [7:0]       tx_mem [0:DEPTH-1];
   logic [FIFO_AW:0] tx_wp;
   logic [FIFO_AW:0] tx_rp;
   logic [FIFO_AW:0] tx_count;
   logic             tx_empty;
   logic             tx_full;
   logic             tx_push;
   logic             tx_pop;
   logic [7:0]       tx_wdata;

   assign tx_count       = tx_wp - tx_rp;
   assign tx_empty       = (tx_wp == tx_rp);
   assign tx_full        = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                           (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
   assign tx_valid       = ~tx_empty;
   assign tx_data        = tx_mem[tx_rp[FIFO_AW-1:0]];
   assign io_buffer_full = (tx_count >= TX_ALMOST);
   assign tx_pop         = tx_valid & tx_ready;
   assign tx_push        = bus_wr & is_io & ~tx_full &
                           (((io_off == 3'd0) && (mem_dout != 8'h00)) || (io_off == 3'd4));
   assign tx_wdata       = (io_off == 3'd4) ? 8'h00 : mem_dout;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push)
            tx_wp <= tx_wp + PTR_ONE;
         if (tx_pop)
            tx_rp <= tx_rp + PTR_ONE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (tx_push)
         tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_wdata;
   end

   // Reading the low counter byte latches all 32 bits so the upper bytes read untorn.
   logic [31:0] counter;
   logic [31:0] snap;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         counter <= '0;
         snap    <= '0;
         halt    <= 1'b0;
      end else begin
         if (rdy_in && !halt)
            counter <= counter + 32'd1;
         if (bus_rd && is_io && (io_off == 3'd4))
            snap <= counter;
         if (bus_wr && is_io && (io_off == 3'd4))
            halt <= 1'b1;
      end
   end

   logic [7:0] rd_data;

   always_comb begin
      rd_data = 8'h00;
      if (is_ram) begin
         rd_data = ram[ram_addr];
      end else if (is_io) begin
         case (io_off)
            3'd0:    rd_data = rx_empty ? 8'h00 : rx_head;
            3'd4:    rd_data = counter[7:0];
            3'd5:    rd_data = snap[15:8];
            3'd6:    rd_data = snap[23:16];
            3'd7:    rd_data = snap[31:24];
            default: rd_data = 8'h00;
         endcase
      end
   end

   // Write cycles leave the previous read data in place.
   always_ff @(posedge clk_in) begin
      if (rst_in)
         mem_din <= 8'h00;
      else if (bus_rd)
         mem_din <= rd_data;
   end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus. Serves 1-cycle-latency RAM reads and 1-cycle writes, and decodes the I/O window at `mem_a[17:16]==2'b11`. The I/O window provides a UART receive FIFO, a UART transmit FIFO, a cycle counter and a program-stop flag. It sits between the `cpu` top and the board-level UART/RAM, and drives the CPU's `mem_din` and `io_buffer_full`.

## Interface
- `RAM_ADDR_W`, 17 — RAM byte-address width (128 KB).
- `FIFO_AW`, 3 — log2 depth of the RX and TX FIFOs (8 entries each).

- `clk_in`  in  1 — the single clock.
- `rst_in`  in  1 — synchronous, active-high reset.
- `rdy_in`  in  1 — when low, the block is frozen: no RAM write, no FIFO push or pop from the bus side, counter holds, `mem_din` holds.
- `mem_a`  in  32 — CPU address; only bits 17:0 are decoded.
- `mem_dout`  in  8 — CPU write data.
- `mem_wr`  in  1 — 1 = write, 0 = read.
- `mem_din`  out  8 — registered read data, valid the cycle after the address.
- `io_buffer_full`  out  1 — TX FIFO count ≥ 2^FIFO_AW − 1.
- `rx_data`  in  8 — incoming UART byte.
- `rx_valid`  in  1 — pushes `rx_data` into the RX FIFO when `rx_ready`.
- `rx_ready`  out  1 — RX FIFO not full.
- `tx_data`  out  8 — TX FIFO head.
- `tx_valid`  out  1 — TX FIFO not empty.
- `tx_ready`  in  1 — pops the TX FIFO when `tx_valid`.
- `halt`  out  1 — sticky program-stop flag.

## Operation
- The bus is sampled every cycle with `rdy_in=1`.
- Region decode on `mem_a[17:16]`:
  - `00`/`01`: RAM, indexed by `mem_a[RAM_ADDR_W-1:0]`.
  - `10`: unmapped. Reads return 0x00; writes are dropped.
  - `11`: I/O, decoded on `mem_a[2:0]`.
- RAM read: `mem_din <= ram[a]`. RAM write: `ram[a] <= mem_dout`; `mem_din` holds its previous value.
- Read 0x30000: if the RX FIFO is non-empty, `mem_din <=` head and pop. If empty, `mem_din <= 0x00` and no pop.
- Read 0x30004: `mem_din <= counter[7:0]` and latch the full counter into `snap`.
- Read 0x30005/6/7: `mem_din <= snap[15:8] / [23:16] / [31:24]`. Reading all four bytes in order therefore gives an untorn 32-bit value.
- Write 0x30000:
  - `mem_dout==0x00` is ignored.
  - Otherwise the byte is pushed to the TX FIFO if it is not full; if full, it is dropped.
- Write 0x30004:
  - Push 0x00 into the TX FIFO if not full.
  - Set `halt`, which stays high until reset.
- Any other I/O offset: reads return 0x00; writes are ignored.
- `counter`:
  - 32 bits, +1 per cycle while `rdy_in=1` and `halt=0`.
  - Wraps from 0xFFFFFFFF to 0.
  - Frozen once `halt` is set.
- RX FIFO: the UART side pushes on `rx_valid & rx_ready`; the bus side pops as described above.
- TX FIFO: the bus side pushes; the UART side pops on `tx_valid & tx_ready`.
- FIFO storage: circular, with pointers of FIFO_AW+1 bits (wrap bit distinguishes full from empty).

## Timing
- Read latency: exactly 1 cycle. The address in cycle N gives data on `mem_din` in cycle N+1.
- Reads never stall. The CPU must not hold `mem_a` at 0x30000 with `mem_wr=0` for more than the intended cycles, because each such cycle pops one byte.
- Writes take effect at the clock edge ending the write cycle. A RAM read of the same address in the next cycle returns the new byte.
- FIFO status: `rx_ready`, `tx_valid` and `io_buffer_full` are combinational from the registered counts and update the cycle after a push or pop.
- Simultaneous FIFO events:
  - RX push and bus pop in the same cycle on a non-empty, non-full FIFO: both happen and the count is unchanged.
  - RX push on an empty FIFO with a same-cycle pop attempt: the read returns 0x00 (no bypass) and the byte is retained.
  - TX push and pop in the same cycle: both occur if not full. If full, the push is dropped even though a pop occurs.
- `io_buffer_full` asserts at one entry below full. This gives one slot of margin for the CPU's one-cycle lag between checking the flag and writing.
- Reset (synchronous) values:
  - 0: `mem_din`, `counter`, `snap`, `halt`, `tx_valid`, `io_buffer_full`.
  - 1: `rx_ready`.
  - Both FIFOs empty.
  - RAM contents are not reset.
- Reset while I/O traffic is in flight discards all FIFO contents.
- `rdy_in=0` in the same cycle as `rst_in=1`: reset wins.
- The UART-side handshakes (`rx_valid`/`rx_ready`, `tx_valid`/`tx_ready`) operate regardless of `rdy_in`.

## Test plan
- RAM write then read:
  - Stimulus: write 0xA5 to 0x00010, then read 0x00010 the next cycle.
  - Required: `mem_din==0xA5` one cycle after the read address.
  - Stimulus: read 0x20000.
  - Required: 0x00.
- RX path:
  - Stimulus: push 0x41 and 0x42 via `rx_valid`, then read 0x30000 three times.
  - Required: `mem_din` returns 0x41, 0x42, then 0x00.
  - Stimulus: fill 8 entries.
  - Required: `rx_ready=0`; a 9th byte is not accepted.
- TX path:
  - Stimulus: with `tx_ready=0`, write 0x30000 with 0x00, then 0x48 ×7.
  - Required: the 0x00 is ignored; `io_buffer_full=1` after the 7th push.
  - Stimulus: an 8th push, then a 9th.
  - Required: the 8th is accepted; the 9th is dropped.
  - Stimulus: raise `tx_ready`.
  - Required: 8 bytes of 0x48 drain.
- Counter snapshot:
  - Stimulus: run 300 cycles from reset, then read 0x30004..0x30007 on consecutive cycles.
  - Required: the bytes assemble to the counter value at the 0x30004 read (untorn).
  - Stimulus: `rdy_in` low for 10 cycles.
  - Required: the counter does not advance.
- Halt:
  - Stimulus: write 0x30004.
  - Required: `halt=1` the next cycle, 0x00 is queued on TX, and the counter freezes.
  - Stimulus: `rst_in` pulse.
  - Required: `halt=0`, the counter is 0 and both FIFOs are empty.
